// File: rtl/reshape_hls_deadlock_report_unit_if.sv
// Signal bundle between the deadlock report unit and the per-process detect units.
interface reshape_hls_deadlock_report_unit_if #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2
);
  logic [PROC_NUM-1:0] dl_detect_vec;
  logic [PROC_NUM-1:0] token_vec;
  logic                dl_detect_in;
  logic [PROC_NUM-1:0] origin;
  logic                token_clear;
  logic                dl_report_valid;
  logic [ID_W-1:0]     dl_report_proc;
  logic [ID_W-1:0]     dl_report_index;
  logic                dl_done;
  logic                dl_timeout;
  logic [ID_W:0]       dl_cycle_len;

  // Detect-unit side: drives detection and token status, receives the broadcasts.
  modport master (
    output dl_detect_vec, token_vec,
    input  dl_detect_in, origin, token_clear, dl_report_valid, dl_report_proc,
    input  dl_report_index, dl_done, dl_timeout, dl_cycle_len
  );

  // Report unit side.
  modport slave (
    input  dl_detect_vec, token_vec,
    output dl_detect_in, origin, token_clear, dl_report_valid, dl_report_proc,
    output dl_report_index, dl_done, dl_timeout, dl_cycle_len
  );
endinterface

// File: rtl/reshape_hls_deadlock_report_unit.sv
// Central deadlock responder: picks an origin on the first detection, follows the
// token around the dependence cycle, reports each process once and latches a
// sticky result (done / timeout / cycle length).
module reshape_hls_deadlock_report_unit #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  reshape_hls_deadlock_report_unit_if.slave    bus
);

  localparam int CNT_W = ID_W + 1;
  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARM, TRACE, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     orig_id, orig_id_nxt;
  logic [PROC_NUM-1:0] visited, visited_nxt;
  logic [PROC_NUM-1:0] pending, pending_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic                detect_in, detect_in_nxt;
  logic [PROC_NUM-1:0] origin_r, origin_nxt;
  logic                rpt_valid, rpt_valid_nxt;
  logic [ID_W-1:0]     rpt_proc, rpt_proc_nxt;
  logic [ID_W-1:0]     rpt_index, rpt_index_nxt;
  logic                done, done_nxt;
  logic                timeout, timeout_nxt;
  logic [CNT_W-1:0]    cycle_len, cycle_len_nxt;
  logic                tok_clear;
  logic [PROC_NUM-1:0] pend_all;
  logic [PROC_NUM-1:0] orig_mask;
  logic [ID_W-1:0]     pick;

  // Index of the lowest set bit; the lowest id always wins ties.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  function automatic logic [PROC_NUM-1:0] onehot(input logic [ID_W-1:0] id);
    return {{(PROC_NUM-1){1'b0}}, 1'b1} << id;
  endfunction

  // Count never needs to exceed the number of processes.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c < CNT_W'(PROC_NUM)) ? c + CNT_W'(1) : c;
  endfunction

  assign orig_mask = onehot(orig_id);

  // Next-state and next-output decode for the trace FSM.
  always_comb begin
    state_nxt     = state;
    orig_id_nxt   = orig_id;
    visited_nxt   = visited;
    pending_nxt   = pending;
    count_nxt     = count;
    timer_nxt     = timer;
    detect_in_nxt = detect_in;
    origin_nxt    = '0;
    rpt_valid_nxt = 1'b0;
    rpt_proc_nxt  = rpt_proc;
    rpt_index_nxt = rpt_index;
    done_nxt      = done;
    timeout_nxt   = timeout;
    cycle_len_nxt = cycle_len;
    tok_clear     = 1'b0;
    pend_all      = '0;
    pick          = '0;

    case (state)
      IDLE: begin
        if (|bus.dl_detect_vec) begin
          pick          = lowest_idx(bus.dl_detect_vec);
          orig_id_nxt   = pick;
          detect_in_nxt = 1'b1;
          origin_nxt    = onehot(pick);
          rpt_valid_nxt = 1'b1;
          rpt_proc_nxt  = pick;
          rpt_index_nxt = '0;
          visited_nxt   = onehot(pick);
          count_nxt     = CNT_W'(1);
          state_nxt     = ARM;
        end
      end
      // One cycle for the units to register origin and emit the token.
      ARM: begin
        timer_nxt = '0;
        state_nxt = TRACE;
      end
      TRACE: begin
        pend_all = pending | (bus.token_vec & ~visited & ~orig_mask);
        if (|(bus.token_vec & orig_mask)) begin
          tok_clear = 1'b1;
          state_nxt = DRAIN;
        end else if (timer == TMR_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = DRAIN;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      // Token is no longer watched; just flush queued processes.
      DRAIN: begin
        pend_all = pending;
        if (pending == '0) begin
          done_nxt      = 1'b1;
          cycle_len_nxt = count;
          state_nxt     = DONE;
        end
      end
      default: ;
    endcase

    // Shared reporting path: one queued process per cycle, lowest id first.
    pending_nxt = ((state == TRACE) || (state == DRAIN)) ? pend_all : pending;
    if (|pend_all) begin
      pick          = lowest_idx(pend_all);
      rpt_valid_nxt = 1'b1;
      rpt_proc_nxt  = pick;
      rpt_index_nxt = count[ID_W-1:0];
      visited_nxt   = visited | onehot(pick);
      pending_nxt   = pend_all & ~onehot(pick);
      count_nxt     = sat_inc(count);
    end
  end

  // State and registered outputs; asynchronous active-low reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      orig_id   <= '0;
      visited   <= '0;
      pending   <= '0;
      count     <= '0;
      timer     <= '0;
      detect_in <= 1'b0;
      origin_r  <= '0;
      rpt_valid <= 1'b0;
      rpt_proc  <= '0;
      rpt_index <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_len <= '0;
    end else begin
      state     <= state_nxt;
      orig_id   <= orig_id_nxt;
      visited   <= visited_nxt;
      pending   <= pending_nxt;
      count     <= count_nxt;
      timer     <= timer_nxt;
      detect_in <= detect_in_nxt;
      origin_r  <= origin_nxt;
      rpt_valid <= rpt_valid_nxt;
      rpt_proc  <= rpt_proc_nxt;
      rpt_index <= rpt_index_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      cycle_len <= cycle_len_nxt;
    end
  end

  assign bus.dl_detect_in    = detect_in;
  assign bus.origin          = origin_r;
  assign bus.token_clear     = tok_clear;
  assign bus.dl_report_valid = rpt_valid;
  assign bus.dl_report_proc  = rpt_proc;
  assign bus.dl_report_index = rpt_index;
  assign bus.dl_done         = done;
  assign bus.dl_timeout      = timeout;
  assign bus.dl_cycle_len    = cycle_len;

endmodule
